// File: rtl/chunk_word_checker.sv
// Per-codeword bit-mismatch checker over a P-lane chunk stream with padding-lane masking.
// Define CHUNK_CHECKER_PIPE_EN to register the popcount ahead of the accumulator.
module chunk_word_checker #(
    parameter int unsigned PARALLELISM = 1,
    parameter int unsigned WORD_LEN    = 1023,
    parameter int unsigned WORD_NUM    = 10,
    parameter int unsigned ERR_CNT_W   = 11
) (
    input  logic                                              clk,
    input  logic                                              in_Arst_n,
    input  logic                                              in_Srst,
    input  logic                                              in_en,
    input  logic [((PARALLELISM == 0) ? 1 : PARALLELISM)-1:0] in_expect_vec,
    input  logic [((PARALLELISM == 0) ? 1 : PARALLELISM)-1:0] in_dut_vec,
    output logic                                              out_word_done,
    output logic [ERR_CNT_W-1:0]                              out_word_err_cnt,
    output logic                                              out_word_pass,
    output logic [$clog2(WORD_NUM+1)-1:0]                     out_word_idx,
    output logic [$clog2(WORD_NUM+1)-1:0]                     out_fail_cnt,
    output logic                                              out_all_done
);
    localparam int unsigned P         = (PARALLELISM == 0) ? 1 : PARALLELISM;
    localparam int unsigned NCHUNK    = (WORD_LEN + P - 1) / P;
    localparam int unsigned REDUNDANT = WORD_LEN % P;
    localparam int unsigned CNT_W     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned IDX_W     = $clog2(WORD_NUM + 1);
    localparam int unsigned PC_W      = $clog2(P + 1);
    localparam int unsigned SUM_W     = ((ERR_CNT_W > PC_W) ? ERR_CNT_W : PC_W) + 1;

    localparam logic [CNT_W-1:0]     LAST_CHUNK = CNT_W'(NCHUNK - 1);
    localparam logic [IDX_W-1:0]     LAST_WORD  = IDX_W'(WORD_NUM - 1);
    localparam logic [ERR_CNT_W-1:0] ACC_MAX    = '1;

    typedef enum logic [0:0] {StRun, StDone} state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [CNT_W-1:0]     r_chunk_cnt;
    logic [ERR_CNT_W-1:0] r_acc;
    logic                 r_done;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 r_pass;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     r_word_cnt;
    logic [IDX_W-1:0]     r_fail_cnt;
    logic                 r_all_done;

    logic                 w_in_acc;
    logic                 w_in_last;
    logic [PC_W-1:0]      w_chunk_err;
    logic                 w_acc_vld;
    logic                 w_acc_last;
    logic [PC_W-1:0]      w_acc_err;
    logic                 w_close;
    logic [SUM_W-1:0]     w_sum;
    logic [ERR_CNT_W-1:0] w_acc_next;

    assign w_in_acc  = in_en && (r_state == StRun);
    assign w_in_last = (r_chunk_cnt == LAST_CHUNK);

    // Only the last chunk of a word can carry padding lanes (lane >= REDUNDANT).
    always_comb begin
        w_chunk_err = '0;
        for (int i = 0; i < int'(P); i++) begin
            if ((in_expect_vec[i] != in_dut_vec[i]) &&
                !(w_in_last && (REDUNDANT != 0) && (i >= int'(REDUNDANT)))) begin
                w_chunk_err = w_chunk_err + PC_W'(1);
            end
        end
    end

`ifdef CHUNK_CHECKER_PIPE_EN
    logic            r_p_vld;
    logic            r_p_last;
    logic [PC_W-1:0] r_p_err;

    always_ff @(posedge clk or negedge in_Arst_n) begin
        if (!in_Arst_n) begin
            r_p_vld  <= 1'b0;
            r_p_last <= 1'b0;
            r_p_err  <= '0;
        end else if (in_Srst) begin
            r_p_vld  <= 1'b0;
            r_p_last <= 1'b0;
            r_p_err  <= '0;
        end else begin
            r_p_vld  <= w_in_acc;
            r_p_last <= w_in_last;
            r_p_err  <= w_chunk_err;
        end
    end

    // A chunk still in flight when the run finishes is dropped here.
    assign w_acc_vld  = r_p_vld && (r_state == StRun);
    assign w_acc_last = r_p_last;
    assign w_acc_err  = r_p_err;
`else
    assign w_acc_vld  = w_in_acc;
    assign w_acc_last = w_in_last;
    assign w_acc_err  = w_chunk_err;
`endif

    assign w_close    = w_acc_vld && w_acc_last;
    assign w_sum      = SUM_W'(r_acc) + SUM_W'(w_acc_err);
    assign w_acc_next = (w_sum > SUM_W'(ACC_MAX)) ? ACC_MAX : w_sum[ERR_CNT_W-1:0];

    always_ff @(posedge clk or negedge in_Arst_n) begin
        if (!in_Arst_n) begin
            r_state <= StRun;
        end else if (in_Srst) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StRun: begin
                if (w_close && (r_word_cnt == LAST_WORD)) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StDone;
            default: w_state_next = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge in_Arst_n) begin
        if (!in_Arst_n) begin
            r_chunk_cnt <= '0;
            r_acc       <= '0;
            r_done      <= 1'b0;
            r_err_cnt   <= '0;
            r_pass      <= 1'b0;
            r_idx       <= '0;
            r_word_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_all_done  <= 1'b0;
        end else if (in_Srst) begin
            r_chunk_cnt <= '0;
            r_acc       <= '0;
            r_done      <= 1'b0;
            r_err_cnt   <= '0;
            r_pass      <= 1'b0;
            r_idx       <= '0;
            r_word_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_all_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_in_acc) begin
                r_chunk_cnt <= w_in_last ? '0 : r_chunk_cnt + CNT_W'(1);
            end
            if (w_acc_vld) begin
                if (w_acc_last) begin
                    r_acc      <= '0;
                    r_done     <= 1'b1;
                    r_err_cnt  <= w_acc_next;
                    r_pass     <= (w_acc_next == '0);
                    r_idx      <= r_word_cnt;
                    r_word_cnt <= r_word_cnt + IDX_W'(1);
                    if (w_acc_next != '0) begin
                        r_fail_cnt <= r_fail_cnt + IDX_W'(1);
                    end
                    if (r_word_cnt == LAST_WORD) begin
                        r_all_done <= 1'b1;
                    end
                end else begin
                    r_acc <= w_acc_next;
                end
            end
        end
    end

    assign out_word_done    = r_done;
    assign out_word_err_cnt = r_err_cnt;
    assign out_word_pass    = r_pass;
    assign out_word_idx     = r_idx;
    assign out_fail_cnt     = r_fail_cnt;
    assign out_all_done     = r_all_done;

endmodule

// File: tb/tb_chunk_word_checker.sv
// Bench for chunk_word_checker (P=4, WORD_LEN=10: two padding lanes in the last chunk),
// directed pins plus random streams against a lane-position reference model.
module tb_chunk_word_checker;
    localparam int P         = 4;
    localparam int WORD_LEN  = 10;
    localparam int WORD_NUM  = 6;
    localparam int ERR_CNT_W = 3;
    localparam int NCHUNK    = (WORD_LEN + P - 1) / P;
    localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;
    localparam int IDX_W     = $clog2(WORD_NUM + 1);
`ifdef CHUNK_CHECKER_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                 clk = 1'b0;
    logic                 in_Arst_n;
    logic                 in_Srst;
    logic                 in_en;
    logic [P-1:0]         in_expect_vec;
    logic [P-1:0]         in_dut_vec;
    logic                 out_word_done;
    logic [ERR_CNT_W-1:0] out_word_err_cnt;
    logic                 out_word_pass;
    logic [IDX_W-1:0]     out_word_idx;
    logic [IDX_W-1:0]     out_fail_cnt;
    logic                 out_all_done;

    chunk_word_checker #(
        .PARALLELISM(P),
        .WORD_LEN   (WORD_LEN),
        .WORD_NUM   (WORD_NUM),
        .ERR_CNT_W  (ERR_CNT_W)
    ) dut (
        .clk             (clk),
        .in_Arst_n       (in_Arst_n),
        .in_Srst         (in_Srst),
        .in_en           (in_en),
        .in_expect_vec   (in_expect_vec),
        .in_dut_vec      (in_dut_vec),
        .out_word_done   (out_word_done),
        .out_word_err_cnt(out_word_err_cnt),
        .out_word_pass   (out_word_pass),
        .out_word_idx    (out_word_idx),
        .out_fail_cnt    (out_fail_cnt),
        .out_all_done    (out_all_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int err;
        int idx;
    } res_t;

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   last_sample_cyc = -100;
    int   dut_done_cyc    = -200;

    // Reference model: bit-position bookkeeping per word, results released after LAT edges.
    res_t q[$];
    int   m_chunk, m_tot, m_fed;
    int   e_done, e_err, e_pass, e_idx, e_fail, e_all;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, want);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_chunk = 0;
        m_tot   = 0;
        m_fed   = 0;
        e_done  = 0;
        e_err   = 0;
        e_pass  = 0;
        e_idx   = 0;
        e_fail  = 0;
        e_all   = 0;
    endtask

    task automatic model_input(input logic en, input logic [P-1:0] ev, input logic [P-1:0] dv);
        res_t r;
        if (en && (m_fed < WORD_NUM)) begin
            for (int i = 0; i < P; i++) begin
                if ((m_chunk * P + i < WORD_LEN) && (ev[i] != dv[i])) m_tot++;
            end
            if (m_chunk == NCHUNK - 1) begin
                r.due = cyc + LAT;
                r.err = (m_tot > ERR_MAX) ? ERR_MAX : m_tot;
                r.idx = m_fed;
                q.push_back(r);
                last_sample_cyc = cyc + 1;
                m_fed++;
                m_chunk = 0;
                m_tot   = 0;
            end else begin
                m_chunk++;
            end
        end
    endtask

    task automatic model_advance();
        res_t r;
        e_done = 0;
        if ((q.size() > 0) && (q[0].due == cyc)) begin
            r      = q.pop_front();
            e_done = 1;
            e_err  = r.err;
            e_pass = (r.err == 0) ? 1 : 0;
            e_idx  = r.idx;
            if (r.err != 0) e_fail++;
            if (r.idx == WORD_NUM - 1) e_all = 1;
        end
    endtask

    task automatic check_outputs();
        if (out_word_done) dut_done_cyc = cyc;
        chk("word_done", int'(out_word_done), e_done);
        chk("word_err_cnt", int'(out_word_err_cnt), e_err);
        chk("word_pass", int'(out_word_pass), e_pass);
        chk("word_idx", int'(out_word_idx), e_idx);
        chk("fail_cnt", int'(out_fail_cnt), e_fail);
        chk("all_done", int'(out_all_done), e_all);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic en, input logic [P-1:0] ev, input logic [P-1:0] dv,
                        input logic srst);
        in_en         = en;
        in_expect_vec = ev;
        in_dut_vec    = dv;
        in_Srst       = srst;
        if (srst) model_clear();
        else      model_input(en, ev, dv);
        @(posedge clk);
        cyc++;
        #1;
        model_advance();
        check_outputs();
        @(negedge clk);
        in_Srst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, P'($urandom), P'($urandom), 1'b0);
    endtask

    task automatic feed(input logic [P-1:0] mask);
        logic [P-1:0] r;
        r = P'($urandom);
        step(1'b1, r, r ^ mask, 1'b0);
    endtask

    task automatic async_reset();
        in_en = 1'b0;
        #2;
        in_Arst_n = 1'b0;
        model_clear();
        #1;
        check_outputs();
        @(posedge clk);
        cyc++;
        #1;
        model_advance();
        check_outputs();
        @(negedge clk);
        in_Arst_n = 1'b1;
    endtask

    function automatic logic [P-1:0] rand_mask();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) return '0;
        if (r < 7) return P'(1 << $urandom_range(0, P - 1));
        if (r < 8) return '1;
        return P'($urandom);
    endfunction

    task automatic run_random(input int en_pct);
        logic [P-1:0] r;
        for (int k = 0; k < 150; k++) begin
            if (m_fed == WORD_NUM) break;
            r = P'($urandom);
            step(($urandom_range(0, 99) < en_pct), r, r ^ rand_mask(), 1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            r = P'($urandom);
            step(1'b1, r, r ^ rand_mask(), 1'b0);
        end
        chk("pin_all_done", int'(out_all_done), 1);
        chk("pin_words_fed", m_fed, WORD_NUM);
    endtask

    initial begin
        in_Arst_n     = 1'b0;
        in_Srst       = 1'b0;
        in_en         = 1'b0;
        in_expect_vec = '0;
        in_dut_vec    = '0;
        model_clear();
        #1;
        check_outputs();
        chk("pin_reset_pass", int'(out_word_pass), 0);
        chk("pin_reset_all", int'(out_all_done), 0);
        @(negedge clk);
        in_Arst_n = 1'b1;

        // Word 0: identical vectors, back-to-back chunks.
        feed(4'b0000); feed(4'b0000); feed(4'b0000);
        idle(LAT);
        chk("pin_latency", dut_done_cyc - last_sample_cyc + 1, LAT);
        chk("pin_w0_err", int'(out_word_err_cnt), 0);
        chk("pin_w0_pass", int'(out_word_pass), 1);

        // Word 1: lanes 0,2 in chunk 0; padding lanes 2,3 of the last chunk are ignored.
        feed(4'b0101); feed(4'b0000); feed(4'b1100);
        idle(LAT);
        chk("pin_w1_err", int'(out_word_err_cnt), 2);
        chk("pin_w1_fail", int'(out_fail_cnt), 1);
        chk("pin_w1_idx", int'(out_word_idx), 1);

        // Word 2: everything inverted, 10 errors saturate to 7.
        feed(4'b1111); feed(4'b1111); feed(4'b1111);
        idle(LAT);
        chk("pin_w2_err", int'(out_word_err_cnt), 7);
        chk("pin_w2_pass", int'(out_word_pass), 0);

        // Word 3: one error per chunk with gaps in between.
        feed(4'b0010); idle(2); feed(4'b0010); idle(1); feed(4'b0010);
        idle(LAT);
        chk("pin_w3_err", int'(out_word_err_cnt), 3);
        chk("pin_w3_fail", int'(out_fail_cnt), 3);

        // Async reset mid-word discards the partial word.
        feed(4'b1111); feed(4'b1111);
        async_reset();
        chk("pin_arst_fail", int'(out_fail_cnt), 0);
        feed(4'b0001); feed(4'b0000); feed(4'b0000);
        idle(LAT);
        chk("pin_arst_idx", int'(out_word_idx), 0);
        chk("pin_arst_err", int'(out_word_err_cnt), 1);

        // Sync reset mid-word; the chunk presented with it is dropped.
        feed(4'b1111);
        step(1'b1, 4'b0000, 4'b1111, 1'b1);
        chk("pin_srst_fail", int'(out_fail_cnt), 0);
        feed(4'b0000); feed(4'b0100); feed(4'b0001);
        idle(LAT);
        chk("pin_srst_idx", int'(out_word_idx), 0);
        chk("pin_srst_err", int'(out_word_err_cnt), 2);

        step(1'b0, 4'b0000, 4'b0000, 1'b1);
        run_random(65);
        step(1'b0, 4'b0000, 4'b0000, 1'b1);
        run_random(100);
        async_reset();
        run_random(40);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/chunk_word_checker.md
Name: chunk_word_checker

Overview:
Downstream consumer of the parallel codeword vector stream. Takes the expected chunk and the DUT (decoder output) chunk each enabled cycle, both PARALLELISM bits wide and word-aligned.
- Counts bit mismatches per codeword; padding lanes past WORD_LEN in the last chunk are masked.
- Reports per-word error count, pass/fail and a running failed-word tally until WORD_NUM words are checked.
- Sits at the tail of the BCH decoder bench/BIST chain.

Parameters:
PARALLELISM, 1, chunk width in bits; 0 is treated as 1.
WORD_LEN, 1023, codeword length in bits.
WORD_NUM, 10, number of codewords in one check run.
ERR_CNT_W, 11, width of the per-word error counter; saturates at all-ones.
NCHUNK (local), ceil(WORD_LEN/P), chunks per word; P is the effective parallelism.
REDUNDANT (local), WORD_LEN % P, valid lanes in the last chunk; 0 means all P lanes are valid.

Ports:
clk  input  1  clock, rising edge.
in_Arst_n  input  1  asynchronous active-low reset.
in_Srst  input  1  synchronous clear; same effect as reset, on the clock edge.
in_en  input  1  chunk valid; both vectors are sampled when high.
in_expect_vec  input  P  expected chunk; lane i is bit position base+i.
in_dut_vec  input  P  DUT chunk, same alignment as the expected chunk.
out_word_done  output  1  one-cycle pulse when a word's result is valid.
out_word_err_cnt  output  ERR_CNT_W  mismatch count of the last completed word.
out_word_pass  output  1  high when out_word_err_cnt==0; valid with and after out_word_done.
out_word_idx  output  clog2(WORD_NUM+1)  index of the last completed word.
out_fail_cnt  output  clog2(WORD_NUM+1)  number of words with a nonzero error count.
out_all_done  output  1  sticky high once WORD_NUM words have completed.

Behaviour:
- Reset (async or sync): all outputs 0, chunk counter 0, accumulator 0, state RUN.
- States:
  - RUN: accepts chunks.
  - DONE: entered the cycle after word WORD_NUM-1 completes. in_en is ignored. Exited only by reset or in_Srst.
- Lane masking: lane i is valid iff chunk_cnt*P+i < WORD_LEN. Invalid lanes contribute 0 even if the vectors differ.
- Chunk error: popcount of (expect XOR dut) over valid lanes.
- Accumulator: acc_next = acc + chunk error, saturating at 2^ERR_CNT_W-1.
- Chunk counter: advances by 1 per accepted chunk. Wraps to 0 after NCHUNK-1.
- Word close (cycle with in_en high at chunk_cnt==NCHUNK-1):
  - Next edge: out_word_err_cnt = acc_next, out_word_done = 1, out_word_idx = word count, word count += 1.
  - out_fail_cnt += 1 if acc_next != 0. Accumulator is cleared to 0 in the same edge.
  - Latency: 1 cycle from the last chunk to out_word_done.
- out_word_done is high for exactly 1 cycle. err_cnt, pass and idx hold until the next word closes.
- in_en low: counters and accumulator hold. Gaps are allowed at any chunk position.
- Back-to-back words: chunk 0 of word k+1 may arrive in the same cycle that word k's done pulse is output. Its errors accumulate from 0.
- out_all_done: set on the same edge as word WORD_NUM-1's done pulse.
- Reset mid-word: the partial accumulation is discarded. No done pulse is issued.
- The RTL implements P==1 and P>1 with the same masked-popcount path.

Optional Feature:
CHUNK_CHECKER_PIPE_EN
- Defined: a register stage sits between the XOR/popcount and the accumulator.
  - Word-close latency becomes 2 cycles.
  - The in_en gating and the last-chunk flag are pipelined alongside the data.
  - Back-to-back and gap behaviour is unchanged.
  - The reset clears the pipeline register.
- Undefined: single-stage path, 1-cycle latency, as above.

Test Plan:
- P=1, WORD_LEN=7, WORD_NUM=2, identical vectors, continuous in_en -> done pulses at cycles 7 and 14. err_cnt=0, pass=1, fail_cnt=0, all_done=1 at cycle 14.
- P=4, WORD_LEN=7: chunk0 differs in lanes 0 and 2; chunk1 differs only in lane 3 (padding) -> err_cnt=2 (padding ignored), fail_cnt=1.
- P=4, WORD_LEN=8 (REDUNDANT=0), all bits inverted -> err_cnt=8, pass=0, done 1 cycle after the 2nd chunk.
- ERR_CNT_W=3, WORD_LEN=16, P=2, all bits wrong -> err_cnt saturates at 7.
- in_en toggled 1,0,0,1 mid-word with 1 error per chunk -> count is unaffected by the gaps. After all_done, extra in_en chunks cause no done pulse and no count change.
- Assert in_Arst_n low mid-word 0, then resume -> outputs 0 immediately (asynchronously). The next completed word reports idx=0 and counts only post-reset errors. Repeat using in_Srst -> same result on the clock edge.
